// File: rtl/port_rst_sched.sv
// port_rst_sched: staggers per-port resets after power-on, then serves soft-reset requests round-robin
module port_rst_sched #(
    parameter int PORT_NUM = 4,
    parameter int HOLD_CYC = 64,
    parameter int GAP_CYC  = 16,
    parameter int CNT_W    = 8,
    parameter int PTR_W    = 2
) (
    input  logic                sys_clk,
    input  logic                rstn_sys,
    input  logic [PORT_NUM-1:0] soft_rst_req,
    output logic [PORT_NUM-1:0] rstn_port,
    output logic [PORT_NUM-1:0] rst_ack,
    output logic                init_done,
    output logic                busy
);
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
    state_t              state_q, state_d;
    logic                init_phase_q, init_phase_d;
    logic [PTR_W-1:0]    cur_q, cur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PORT_NUM-1:0] pend_q, pend_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PORT_NUM-1:0] rstn_port_q, rstn_port_d;
    logic [PORT_NUM-1:0] rst_ack_q, rst_ack_d;
    logic                init_done_q, init_done_d;
    logic [PORT_NUM-1:0] grant;
    logic [PTR_W-1:0]    sel, idx;
    logic                found;
    // Scan downwards so the earliest port after rr_ptr is the last one written
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = PORT_NUM; i >= 1; i--) begin
            idx = PTR_W'((int'(rr_ptr_q) + i) % PORT_NUM);
            if (pend_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d      = state_q;
        init_phase_d = init_phase_q;
        cur_d        = cur_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        rstn_port_d  = rstn_port_q;
        rst_ack_d    = '0;
        init_done_d  = init_done_q;
        grant        = '0;
        case (state_q)
            S_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    rstn_port_d[cur_q] = 1'b1;
                    cnt_d              = '0;
                    state_d            = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (init_phase_q && cur_q == PTR_W'(PORT_NUM - 1)) begin
                        init_done_d  = 1'b1;
                        init_phase_d = 1'b0;
                        state_d      = S_IDLE;
                    end else if (init_phase_q) begin
                        cur_d   = cur_q + PTR_W'(1);
                        state_d = S_HOLD;
                    end else begin
                        rst_ack_d[cur_q] = 1'b1;
                        rr_ptr_d         = cur_q;
                        state_d          = S_IDLE;
                    end
                end
            end
            default: begin
                if (found) begin
                    cur_d            = sel;
                    rstn_port_d[sel] = 1'b0;
                    grant[sel]       = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_HOLD;
                end
            end
        endcase
    end
    // A request arriving in the grant cycle stays pending and is served again
    assign pend_d = (pend_q & ~grant) | soft_rst_req;
    always_ff @(posedge sys_clk) begin
        if (!rstn_sys) begin
            state_q      <= S_HOLD;
            init_phase_q <= 1'b1;
            cur_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            rr_ptr_q     <= PTR_W'(PORT_NUM - 1);
            rstn_port_q  <= '0;
            rst_ack_q    <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_phase_q <= init_phase_d;
            cur_q        <= cur_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            rr_ptr_q     <= rr_ptr_d;
            rstn_port_q  <= rstn_port_d;
            rst_ack_q    <= rst_ack_d;
            init_done_q  <= init_done_d;
        end
    end
    assign rstn_port = rstn_port_q;
    assign rst_ack   = rst_ack_q;
    assign init_done = init_done_q;
    assign busy      = state_q != S_IDLE;
endmodule

// File: doc/port_rst_sched.md
Name: port_rst_sched

Overview:
Per-port reset scheduler in the sys_clk domain, downstream of the top-level reset controller. After system reset release it brings the switch ports out of reset one at a time, staggered. It then serves software or link-manager soft-reset requests per port, one port at a time, with round-robin arbitration. It guarantees a minimum reset pulse width and a settle gap after each release, so per-port FIFOs and MAC logic initialise cleanly.

Parameters:
PORT_NUM, 4, number of switch ports (2..16)
HOLD_CYC, 64, sys_clk cycles a port's rstn stays low per reset (>=1)
GAP_CYC, 16, settle cycles after a release before the next port is handled (>=1)
CNT_W, 8, counter width; 2^CNT_W must be >= max(HOLD_CYC, GAP_CYC)
PTR_W, 2, port index width, >= clog2(PORT_NUM)

Ports:
sys_clk  in  1  system clock
rstn_sys  in  1  synchronous active-low reset, sampled on posedge sys_clk
soft_rst_req  in  PORT_NUM  per-port reset request; one-cycle pulse or level; latched into pending
rstn_port  out  PORT_NUM  per-port active-low reset, registered
rst_ack  out  PORT_NUM  one-cycle pulse when a soft reset of that port has fully completed, including the gap
init_done  out  1  high from end of power-on sequence onwards
busy  out  1  high whenever state != S_IDLE

Behaviour:
- Reset is synchronous active-low on rstn_sys. One clock only: sys_clk.
- Reset values:
  - rstn_port = all 0; rst_ack = 0; init_done = 0; busy = 1.
  - state = S_HOLD, init_phase = 1, cur = 0, cnt = 0.
  - pend = 0; rr_ptr = PORT_NUM-1.
- Reset mid-operation aborts everything, clears pending requests and restarts the power-on sequence.
- States:
  - S_HOLD: port cur is held low. cnt increments each cycle. On cnt == HOLD_CYC-1: rstn_port[cur] <= 1, cnt <= 0, go to S_GAP.
  - S_GAP: cnt increments. On cnt == GAP_CYC-1, cnt <= 0, then:
    - init_phase and cur == PORT_NUM-1: init_done <= 1, init_phase <= 0, go to S_IDLE.
    - init_phase otherwise: cur <= cur+1, go to S_HOLD. That port is already low.
    - soft reset: rst_ack[cur] <= 1 for one cycle, rr_ptr <= cur, go to S_IDLE.
  - S_IDLE: if pend != 0, grant sel = first set bit scanning (rr_ptr+1) .. (rr_ptr+PORT_NUM) mod PORT_NUM. Then cur <= sel, rstn_port[sel] <= 0, pend[sel] <= 0, cnt <= 0, go to S_HOLD. Otherwise stay in S_IDLE.
- Pending logic: pend <= (pend | soft_rst_req) with the grant bit cleared. A set and a clear of the same bit in the same cycle: set wins, so the request is re-served later.
- Requests arriving during init or during another port's service are latched and served afterwards. No request is ever dropped.
- Only one port is in soft reset at a time. Ports not being served keep their rstn_port value.
- Power-on timing, with cycle 0 = first cycle rstn_sys = 1:
  - rstn_port[i] rises at cycle (i+1)*HOLD_CYC + i*GAP_CYC.
  - init_done rises at PORT_NUM*(HOLD_CYC+GAP_CYC).
- Soft-reset latency, for a request pulse at cycle t with the block idle and pend empty:
  - pend visible at t+1.
  - rstn_port low at t+2, held exactly HOLD_CYC cycles, high at t+2+HOLD_CYC.
  - rst_ack pulse at t+2+HOLD_CYC+GAP_CYC.
  - The next grant can occur the cycle after ack.
- A level-held request re-triggers continuously, with one full reset per grant.
- Counters never wrap in legal configurations. An out-of-range parameter is a configuration error; the bench checks it with an assertion.

Test Plan:
- Power-on with defaults: release rstn_sys -> rstn_port[0..3] rise at cycles 64/144/224/304; init_done rises at 320; rst_ack stays 0 throughout; busy falls at 320.
- Single soft reset: after init, pulse soft_rst_req = 4'b0100 at t -> rstn_port[2] low for cycles t+2..t+65; rst_ack = 4'b0100 at t+82 only; other ports stay high.
- Round-robin: pulse soft_rst_req = 4'b1011 in one cycle after init -> served order 0, 1, 3, each with a full 64+16 cycle window. Then pulse 4'b0011 -> served order 0, 1, since rr_ptr = 3 so the scan starts at port 0.
- Request during init: pulse soft_rst_req[1] at cycle 10 -> latched; after init_done, port 1 is reset once and acked; no early action.
- Re-request during service: while port 2 is in S_HOLD, pulse soft_rst_req[2] again -> port 2 gets a second complete reset after the first ack; two acks total.
- Mid-sequence reset: assert rstn_sys low during a soft reset of port 3 -> next cycle all rstn_port = 0, pend = 0, init_done = 0; after release the power-on timing is identical to the first scenario.
